// File: rtl/reverb_tap_engine_pkg.sv
// Shared definitions for the reverb tap engine: FSM encoding, tap-word layout, output limits.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package reverb_tap_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_TAP_RD = 3'd2,
        ST_SMP_RD = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_COEF_W   = 8;
    localparam int DEF_MAX_TAPS = 512;
    localparam int DEF_ACC_W    = 32;

    // Tap word layout, MSB first: {delta (unsigned), neg, gain magnitude}.
    function automatic int tap_neg_bit(input int coef_w);
        return coef_w;
    endfunction

    function automatic int tap_delta_lsb(input int coef_w);
        return coef_w + 1;
    endfunction

    function automatic int tap_delta_w(input int data_w, input int coef_w);
        return data_w - 1 - coef_w;
    endfunction

    // Two's-complement limits of a data_w-bit signed sample.
    function automatic longint sat_hi(input int data_w);
        return (longint'(1) << (data_w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int data_w);
        return -(longint'(1) << (data_w - 1));
    endfunction

endpackage

// File: rtl/reverb_tap_engine_tap_mac.sv
// Signed tap multiply-accumulate with final wet shift, dry mix and output saturation.
// Latency: accumulator updates one cycle after acc_en; sat_out is combinational from acc and inputs.
// Backpressure: none; the caller gates acc_en on the memory handshake.
module reverb_tap_engine_tap_mac
    import reverb_tap_engine_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] sample,
    input  logic [COEF_W-1:0] gain,
    input  logic              neg,
    input  logic              mix_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sat_out
);

    localparam int PW = DATA_W + COEF_W + 1;
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'(sat_hi(DATA_W));
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W + 1)'(sat_lo(DATA_W));

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [PW-1:0]    s_ext, g_ext, prod, term;
    logic signed [ACC_W:0]   wet, dry, sum;

    // Next accumulator: clear at sample start, else add the signed tap product when enabled.
    always_comb begin
        s_ext = PW'($signed(sample));
        g_ext = PW'({1'b0, gain});
        prod  = s_ext * g_ext;
        term  = neg ? -prod : prod;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + ACC_W'(term);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Wet level drops the gain fraction bits, adds the optional dry path, then clamps.
    always_comb begin
        wet = (ACC_W + 1)'(acc_q >>> COEF_W);
        dry = mix_en ? (ACC_W + 1)'($signed(din)) : '0;
        sum = wet + dry;
        if (sum > SAT_HI) begin
            sat_out = SAT_HI[DATA_W-1:0];
        end else if (sum < SAT_LO) begin
            sat_out = SAT_LO[DATA_W-1:0];
        end else begin
            sat_out = sum[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/reverb_tap_engine.sv
// Per-sample reverb: writes the input into a ring buffer, then walks a sparse tap table doing MACs.
// Latency: zero-wait memory gives dout_valid 2n+3 cycles after tick (record=1), 2n+2 (record=0).
// Backpressure: every access holds mem_req and its address/data until mem_ready; ticks while busy are dropped and flagged.
module reverb_tap_engine
    import reverb_tap_engine_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int COEF_W   = DEF_COEF_W,
    parameter int MAX_TAPS = DEF_MAX_TAPS,
    parameter int ACC_W    = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adc_tick,
    input  logic [DATA_W-1:0] din,
    input  logic              record,
    input  logic              mix_en,
    input  logic [ADDR_W-1:0] num_taps,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int NEG_BIT   = tap_neg_bit(COEF_W);
    localparam int DELTA_LSB = tap_delta_lsb(COEF_W);
    localparam int DELTA_W   = tap_delta_w(DATA_W, COEF_W);
    localparam int MAX_CL    = (MAX_TAPS < (2 ** ADDR_W) - 1) ? MAX_TAPS : (2 ** ADDR_W) - 1;
    localparam logic [ADDR_W-1:0] MAX_N    = ADDR_W'(MAX_CL);
    localparam logic [ADDR_W-1:0] RING_TOP = '1;
    localparam logic [ADDR_W:0]   D_MAX    = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   n_q, n_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [ADDR_W:0]     d_q, d_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                record_q, record_d;
    logic                mix_q, mix_d;
    logic                neg_q, neg_d;
    logic [COEF_W-1:0]   gain_q, gain_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                overrun_q, overrun_d;

    logic [ADDR_W-1:0]   n_new;
    logic [ADDR_W:0]     ring_len;
    logic                skip;
    logic [ADDR_W:0]     raw_ext;
    logic [ADDR_W-1:0]   raw, smp_addr, i_nxt;
    logic [DELTA_W-1:0]  tap_delta;
    logic [ADDR_W+1:0]   d_sum;
    logic                mac_clr, mac_en;
    logic [DATA_W-1:0]   mac_out;

    // Ring geometry: table at [0,n), ring at [n, top]; delays beyond the ring length contribute nothing.
    always_comb begin
        n_new     = (num_taps > MAX_N) ? MAX_N : num_taps;
        ring_len  = {1'b1, {ADDR_W{1'b0}}} - {1'b0, n_q};
        skip      = (d_q >= ring_len);
        raw_ext   = {1'b0, wr_ptr_q} - d_q;
        raw       = raw_ext[ADDR_W-1:0];
        // Adding the ring length modulo 2^ADDR_W is the same as subtracting n.
        smp_addr  = (raw_ext[ADDR_W] || (raw < n_q)) ? (raw - n_q) : raw;
        tap_delta = mem_rdata[DATA_W-1:DELTA_LSB];
        d_sum     = {1'b0, d_q} + (ADDR_W + 2)'(tap_delta);
        i_nxt     = i_q + 1'b1;
    end

    // FSM next state, memory port drive and datapath register updates.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        n_d          = n_q;
        i_d          = i_q;
        d_d          = d_q;
        din_d        = din_q;
        record_d     = record_q;
        mix_d        = mix_q;
        neg_d        = neg_q;
        gain_d       = gain_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overrun_d    = adc_tick && (state_q != ST_IDLE);
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state_q)
            ST_IDLE: begin
                if (adc_tick) begin
                    din_d    = din;
                    record_d = record;
                    mix_d    = mix_en;
                    n_d      = n_new;
                    i_d      = '0;
                    d_d      = '0;
                    mac_clr  = 1'b1;
                    if (wr_ptr_q < n_new) begin
                        wr_ptr_d = n_new;
                    end
                    if (record) begin
                        state_d = ST_WRITE;
                    end else if (n_new == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_TAP_RD;
                    end
                end
            end
            ST_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_ptr_q;
                mem_wdata = din_q;
                if (mem_ready) begin
                    state_d = (n_q == '0) ? ST_DONE : ST_TAP_RD;
                end
            end
            ST_TAP_RD: begin
                mem_req  = 1'b1;
                mem_addr = i_q;
                if (mem_ready) begin
                    d_d     = d_sum[ADDR_W+1] ? D_MAX : d_sum[ADDR_W:0];
                    neg_d   = mem_rdata[NEG_BIT];
                    gain_d  = mem_rdata[COEF_W-1:0];
                    state_d = ST_SMP_RD;
                end
            end
            ST_SMP_RD: begin
                mem_req  = !skip;
                mem_addr = skip ? '0 : smp_addr;
                if (skip || mem_ready) begin
                    mac_en  = !skip;
                    i_d     = i_nxt;
                    state_d = (i_nxt < n_q) ? ST_TAP_RD : ST_DONE;
                end
            end
            ST_DONE: begin
                dout_d       = mac_out;
                dout_valid_d = 1'b1;
                if (record_q) begin
                    wr_ptr_d = (wr_ptr_q == RING_TOP) ? n_q : (wr_ptr_q + 1'b1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            n_q          <= '0;
            i_q          <= '0;
            d_q          <= '0;
            din_q        <= '0;
            record_q     <= 1'b0;
            mix_q        <= 1'b0;
            neg_q        <= 1'b0;
            gain_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            n_q          <= n_d;
            i_q          <= i_d;
            d_q          <= d_d;
            din_q        <= din_d;
            record_q     <= record_d;
            mix_q        <= mix_d;
            neg_q        <= neg_d;
            gain_q       <= gain_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    reverb_tap_engine_tap_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_tap_mac (
        .clk     (clk),
        .reset   (reset),
        .clr     (mac_clr),
        .acc_en  (mac_en),
        .sample  (mem_rdata),
        .gain    (gain_q),
        .neg     (neg_q),
        .mix_en  (mix_q),
        .din     (din_q),
        .sat_out (mac_out)
    );

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/reverb_tap_engine.md
Name: reverb_tap_engine

Overview:
- Parametrised successor of the on-chip/off-chip memory controller.
- Keeps a circular sample buffer and a sparse impulse (tap) table in one shared memory space. Once per audio sample it writes the new input and walks up to MAX_TAPS taps. Each tap costs one coefficient read and one delayed-sample read, followed by a signed multiply-accumulate.
- Produces a saturated dry+wet output.
- Sits between the ADC sample path and the SRAM / off-chip memory arbiter. A single req/ready handshake covers both memory types.

Parameters:
DATA_W, 16, sample and memory word width
ADDR_W, 16, memory address width; ring top = 2^ADDR_W-1
COEF_W, 8, tap gain magnitude width; delta field = DATA_W-1-COEF_W bits
MAX_TAPS, 512, clamp for num_taps
ACC_W, 32, accumulator width

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
adc_tick  in  1  one-cycle sample strobe, synchronous to clk
din  in  DATA_W  signed input sample, valid on adc_tick
record  in  1  1 = write din into ring and advance wr_ptr; 0 = ring frozen (loop playback)
mix_en  in  1  1 = output din + wet; 0 = wet only
num_taps  in  ADDR_W  tap-table length; table occupies [0, num_taps)
mem_req  out  1  access request, held until mem_ready
mem_we  out  1  write strobe qualifying mem_req
mem_addr  out  ADDR_W  access address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid when mem_ready
mem_ready  in  1  access complete this cycle
dout  out  DATA_W  signed saturated output sample
dout_valid  out  1  one-cycle pulse when dout updates
busy  out  1  high from tick acceptance to DONE
overrun  out  1  one-cycle pulse when adc_tick arrives while busy

Behaviour:
- Reset values: all outputs 0; wr_ptr = 0; state = IDLE. Reset mid-operation aborts the access and drops mem_req the next cycle.
- States and transitions:
  - IDLE: on adc_tick, latch din, record, mix_en and n = min(num_taps, MAX_TAPS). Clear acc, cumulative delay d and tap index i. If wr_ptr < n, set wr_ptr = n. Go to WRITE if record, else TAP_RD (DONE if n = 0).
  - WRITE: mem_we = 1, addr = wr_ptr, data = din. On ready go to TAP_RD, or DONE if n = 0.
  - TAP_RD: read addr i. On ready, decode the tap word:
    - delta = [DATA_W-1:COEF_W+1], unsigned
    - neg = [COEF_W]
    - g = [COEF_W-1:0]
    - d += delta
    - go to SMP_RD
  - SMP_RD: read addr = wr_ptr - d. If the result is < n (including unsigned underflow), add ring length L = 2^ADDR_W - n. On ready, acc += (neg ? -1 : 1) * sample * g, signed. If d >= L, skip the access and add 0. Then i++; go to TAP_RD if i < n, else DONE.
  - DONE: wet = acc >>> COEF_W (arithmetic). sum = (mix_en ? din : 0) + wet. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register into dout. Pulse dout_valid next cycle. If record, advance wr_ptr: wr_ptr == 2^ADDR_W-1 wraps to n, else +1. Return to IDLE.
- mem_req is deasserted in IDLE and DONE. Address, data and we are stable while mem_req is high and mem_ready is low.
- Latency with zero-wait memory (mem_ready tied 1), tick at cycle 0: dout_valid at cycle 2n+3 with record = 1, 2n+2 with record = 0. Each wait cycle adds one.
- Delay 0 reads the sample just written (or the stale sample when record = 0).
- adc_tick while busy: pulse overrun, drop the tick, leave dout unchanged.
- adc_tick in the same cycle as reset: reset wins.
- num_taps changes take effect only at the next accepted tick.

Decomposition:
- Shared package holds:
  - the state encoding
  - tap-word field positions derived from DATA_W/COEF_W
  - saturation limits
- Sub-module tap_mac: signed multiply, negation, accumulate and final shift/saturate; pure datapath with an accumulate-enable and a clear.
- FSM and address/wrap arithmetic stay in reverb_tap_engine.

Test Plan:
1. Reset held 3 cycles mid-WRITE -> dout=0, dout_valid=0, mem_req=0, busy=0; next tick writes addr 0.
2. ADDR_W=8, num_taps=0, record=1, din=0x1234 -> write at addr 0 with data 0x1234; dout=0x1234 with dout_valid at cycle 3; next write goes to addr 1.
3. num_taps=1, tap word 0x0480 (delta 2, +, g=128), mix_en=0, samples 0x4000, 0, 0 -> third output 0x2000; first two outputs 0.
4. Tap 0x00FF (delta 0, g=255), mix_en=1, din=0x7000 -> dout=0x7FFF. Tap 0x01FF with din=0x7000 -> 0x0070. Tap 0x00FF with din=0x9000 -> 0x8000.
5. ADDR_W=8, num_taps=4:
   - wr_ptr=255 write -> next wr_ptr 4.
   - wr_ptr=5, cumulative delay 3 -> sample read addr 254.
   - Delay 252 (>= L) -> no sample access, zero contribution.
6. mem_ready held low 5 cycles per access, second adc_tick while busy -> overrun pulse; exactly one dout_valid; latency grows by 5 per access; mem_addr stable while waiting.
